// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - EX/MEM boundary register with 2-entry skid buffer, commit gating and flush
// Optional feature macro: EX_MEM_STALL_CNT_EN (adds stall_cycles back-pressure counter)
module ex_mem_skid_stage #(
   parameter int DATA_W = 111,
   parameter int WE_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_act,
   input  logic [DATA_W-1:0] in_data,
   input  logic [WE_W-1:0]   in_we,
   input  logic              in_wer,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [WE_W-1:0]   out_we,
   output logic              out_wer,
   output logic [1:0]        occupancy
`ifdef EX_MEM_STALL_CNT_EN
   ,output logic [31:0]      stall_cycles
`endif
);

   logic              main_v_q, main_v_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [WE_W-1:0]   main_we_q, main_we_d;
   logic              main_wer_q, main_wer_d;
   logic              skid_v_q, skid_v_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [WE_W-1:0]   skid_we_q, skid_we_d;
   logic              skid_wer_q, skid_wer_d;

   logic              acc;
   logic              drn;
   logic [WE_W-1:0]   gated_we;
   logic              gated_wer;

   // Handshake decode and commit gating of side effects; payload passes through untouched
   always_comb begin
      acc       = in_valid & in_ready;
      drn       = main_v_q & out_ready;
      gated_we  = in_we & {WE_W{in_act}};
      gated_wer = in_wer & in_act;
   end

   // Next-state: main is the head of a 2-deep FIFO, skid only ever fills behind a stalled main
   always_comb begin
      main_v_d    = main_v_q;
      main_data_d = main_data_q;
      main_we_d   = main_we_q;
      main_wer_d  = main_wer_q;
      skid_v_d    = skid_v_q;
      skid_data_d = skid_data_q;
      skid_we_d   = skid_we_q;
      skid_wer_d  = skid_wer_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (!main_v_q || (drn && !skid_v_q)) begin
         // Main is free this cycle: fill from input or go empty
         main_v_d = acc;
         if (acc) begin
            main_data_d = in_data;
            main_we_d   = gated_we;
            main_wer_d  = gated_wer;
         end
      end else if (drn) begin
         // Skid is full and in_ready is low, so promote skid with no new accept
         main_v_d    = 1'b1;
         main_data_d = skid_data_q;
         main_we_d   = skid_we_q;
         main_wer_d  = skid_wer_q;
         skid_v_d    = 1'b0;
      end else if (acc) begin
         skid_v_d    = 1'b1;
         skid_data_d = in_data;
         skid_we_d   = gated_we;
         skid_wer_d  = gated_wer;
      end
   end

   // State registers, asynchronously cleared so a mid-transfer reset drops everything at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_v_q    <= 1'b0;
         main_data_q <= '0;
         main_we_q   <= '0;
         main_wer_q  <= 1'b0;
         skid_v_q    <= 1'b0;
         skid_data_q <= '0;
         skid_we_q   <= '0;
         skid_wer_q  <= 1'b0;
      end else begin
         main_v_q    <= main_v_d;
         main_data_q <= main_data_d;
         main_we_q   <= main_we_d;
         main_wer_q  <= main_wer_d;
         skid_v_q    <= skid_v_d;
         skid_data_q <= skid_data_d;
         skid_we_q   <= skid_we_d;
         skid_wer_q  <= skid_wer_d;
      end
   end

   // Outputs from main; side-effect strobes masked so stale data never writes after a flush
   always_comb begin
      out_valid = main_v_q;
      out_data  = main_data_q;
      out_we    = main_we_q & {WE_W{main_v_q}};
      out_wer   = main_wer_q & main_v_q;
      in_ready  = ~skid_v_q;
      occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
   end

`ifdef EX_MEM_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   // Count cycles where MEM holds off a valid entry; wraps naturally, survives flush
   always_comb begin
      stall_d = stall_q + {31'b0, main_v_q & ~out_ready};
   end

   // Stall counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb/tb_ex_mem_skid_stage.sv - randomized and directed check of ex_mem_skid_stage against a queue model
module tb_ex_mem_skid_stage;

   localparam int DW = 111;
   localparam int WW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_act;
   logic [DW-1:0] in_data;
   logic [WW-1:0] in_we;
   logic          in_wer;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [WW-1:0] out_we;
   logic          out_wer;
   logic [1:0]    occupancy;
`ifdef EX_MEM_STALL_CNT_EN
   logic [31:0]   stall_cycles;
`endif

   ex_mem_skid_stage #(.DATA_W(DW), .WE_W(WW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
      .in_data(in_data), .in_we(in_we), .in_wer(in_wer),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_we(out_we), .out_wer(out_wer), .occupancy(occupancy)
`ifdef EX_MEM_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [WW-1:0] we;
      logic          wer;
   } ent_t;

   ent_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Compare every observable output with the FIFO model
   task automatic check_all();
      int n;
      n = q.size();
      chk("occupancy", 128'(occupancy), 128'(n));
      chk("in_ready", 128'(in_ready), 128'(n < 2));
      chk("out_valid", 128'(out_valid), 128'(n > 0));
      chk("out_we", 128'(out_we), (n > 0) ? 128'(q[0].we) : 128'(0));
      chk("out_wer", 128'(out_wer), (n > 0) ? 128'(q[0].wer) : 128'(0));
      if (n > 0) chk("out_data", 128'(out_data), 128'(q[0].d));
   endtask

   // One clock of stimulus; the model is a depth-2 FIFO with ready = not full
   task automatic step(input logic iv, input logic [DW-1:0] d, input logic [WW-1:0] we,
                       input logic wer, input logic act, input logic ordy, input logic fl);
      logic acc, drn;
      ent_t e;
      in_valid  = iv;
      in_data   = d;
      in_we     = we;
      in_wer    = wer;
      in_act    = act;
      out_ready = ordy;
      flush     = fl;
      acc = iv && (q.size() < 2);
      drn = (q.size() > 0) && ordy;
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) begin
            e.d   = d;
            e.we  = act ? we : '0;
            e.wer = wer & act;
            q.push_back(e);
         end
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_we = '0; in_wer = 1'b0; in_act = 1'b1;
      out_ready = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      check_all();
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[DW-1:0];
   endfunction

   initial begin
      logic [DW-1:0] a, b, c;
      do_reset();
      chk("rst_ready", 128'(in_ready), 128'(1));
      chk("rst_data", 128'(out_data), 128'(0));

      // Stream 1,2,3 with MEM always ready
      step(1, 1, 4'h1, 1, 1, 1, 0); chk("s1", 128'(out_data), 128'(1));
      step(1, 2, 4'h2, 0, 1, 1, 0); chk("s2", 128'(out_data), 128'(2));
      step(1, 3, 4'h4, 1, 1, 1, 0); chk("s3", 128'(out_data), 128'(3));
      chk("s_occ", 128'(occupancy), 128'(1));
      step(0, 0, 0, 0, 1, 1, 0);

      // Back-pressure: A then B held, then drained in order
      a = rnd_data(); b = rnd_data(); c = rnd_data();
      step(1, a, 4'h3, 1, 1, 0, 0);
      step(1, b, 4'hc, 0, 1, 0, 0);
      chk("bp_occ", 128'(occupancy), 128'(2));
      chk("bp_rdy", 128'(in_ready), 128'(0));
      step(1, c, 4'h0, 0, 1, 0, 0);
      chk("bp_hold", 128'(out_data), 128'(a));
      step(0, 0, 0, 0, 1, 1, 0);
      chk("bp_b", 128'(out_data), 128'(b));
      chk("bp_rdy1", 128'(in_ready), 128'(1));
      step(0, 0, 0, 0, 1, 1, 0);

      // Kill: side effects dropped, payload kept
      step(1, a, 4'hf, 1, 0, 0, 0);
      chk("kill_we", 128'(out_we), 128'(0));
      chk("kill_wer", 128'(out_wer), 128'(0));
      chk("kill_data", 128'(out_data), 128'(a));
      step(0, 0, 0, 0, 1, 1, 0);

      // Flush with full buffer and a same-cycle push
      step(1, a, 4'hf, 1, 1, 0, 0);
      step(1, b, 4'hf, 1, 1, 0, 0);
      step(1, c, 4'hf, 1, 1, 0, 1);
      chk("fl_occ", 128'(occupancy), 128'(0));
      chk("fl_we", 128'(out_we), 128'(0));

      // Async reset between edges while full
      step(1, a, 4'h1, 1, 1, 0, 0);
      step(1, b, 4'h2, 1, 1, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", 128'(out_valid), 128'(0));
      chk("ar_occ", 128'(occupancy), 128'(0));
      chk("ar_rdy", 128'(in_ready), 128'(1));
      do_reset();

`ifdef EX_MEM_STALL_CNT_EN
      step(1, a, 4'h1, 1, 1, 0, 0);
      repeat (5) step(0, 0, 0, 0, 1, 0, 0);
      chk("stall5", 128'(stall_cycles), 128'(5));
      step(0, 0, 0, 0, 1, 1, 0);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(logic'($urandom_range(0, 3) != 0), rnd_data(), WW'($urandom),
              logic'($urandom), logic'($urandom_range(0, 3) != 0),
              logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 15) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
